// File: rtl/alg_amba_vip_interleaver.sv
// Per-ID reorder/interleave stage for VIP R/B responses; ALG_AMBA_VIP_INTERLEAVER_STATS_EN adds beat/switch counters.
// Latency: beat accepted in cycle T is presented in cycle T+2 (uncontended, no gap); 1 beat/cycle sustained.
// Backpressure: s_ready drops per ID when its FIFO is full or disabled; m_* hold while m_valid & ~m_ready.
module alg_amba_vip_interleaver #(
    parameter int DATA_WIDTH      = 128,
    parameter int ID_WIDTH        = 4,
    parameter int FIFO_LOG2_DEPTH = 2,
    parameter int GAP_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [1:0]            arb_mode,
    input  logic                  burst_lock,
    input  logic [(1<<ID_WIDTH)-1:0] id_enable,
    input  logic [GAP_WIDTH-1:0]  gap_min,
    input  logic [GAP_WIDTH-1:0]  gap_mask,
    input  logic [15:0]           seed,
    input  logic                  seed_rst,
    input  logic                  stats_clr,
    output logic [31:0]           stat_beats,
    output logic [31:0]           stat_switches,
    input  logic                  s_valid,
    input  logic [ID_WIDTH-1:0]   s_id,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [ID_WIDTH-1:0]   m_id,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);
    localparam int N     = 1 << ID_WIDTH;
    localparam int DEPTH = 1 << FIFO_LOG2_DEPTH;
    localparam int CW    = FIFO_LOG2_DEPTH + 1;
    localparam int EW    = DATA_WIDTH + 1;

    logic [EW-1:0]              mem     [N][DEPTH];
    logic [FIFO_LOG2_DEPTH-1:0] wr_ptr  [N];
    logic [FIFO_LOG2_DEPTH-1:0] rd_ptr  [N];
    logic [CW-1:0]              cnt     [N];
    logic [CW-1:0]              cnt_nxt [N];
    logic [N-1:0]               full_q;
    logic [N-1:0]               empty;
    logic [N-1:0]               we;
    logic [N-1:0]               pop;
    logic [N-1:0]               cand;
    logic                       wr_en;
    logic                       issue;
    logic                       found;
    logic [ID_WIDTH-1:0]        grant;
    logic [ID_WIDTH-1:0]        start;
    logic [ID_WIDTH-1:0]        idx;
    logic [ID_WIDTH-1:0]        rr_ptr;
    logic                       lock_vld;
    logic [ID_WIDTH-1:0]        lock_id;
    logic [GAP_WIDTH-1:0]       gap_cnt;
    logic [GAP_WIDTH:0]         gap_sum;
    logic [GAP_WIDTH-1:0]       gap_load;
    logic [15:0]                lfsr;
    logic [15:0]                seed_eff;
    logic [EW-1:0]              pop_ent;

    assign s_ready  = id_enable[s_id] & ~full_q[s_id];
    assign wr_en    = s_valid & s_ready;
    assign we       = wr_en ? (N'(1) << s_id) : '0;
    assign pop      = issue ? (N'(1) << grant) : '0;
    assign pop_ent  = mem[grant][rd_ptr[grant]];
    assign seed_eff = (seed == 16'h0) ? 16'hACE1 : seed;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            empty[i]   = (cnt[i] == '0);
            cnt_nxt[i] = cnt[i] + CW'(we[i]) - CW'(pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[s_id][wr_ptr[s_id]] <= {s_last, s_data};
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!resetn) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
                full_q[i] <= 1'b0;
            end else begin
                if (we[i])  wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                cnt[i]    <= cnt_nxt[i];
                full_q[i] <= (cnt_nxt[i] == CW'(DEPTH));
            end
        end
    end

    // Search starts at a mode-dependent ID and wraps; ID_WIDTH-bit arithmetic gives the modulo.
    always_comb begin
        cand = ~empty & id_enable;
        if (burst_lock && lock_vld) cand = cand & (N'(1) << lock_id);
        case (arb_mode)
            2'd1:    start = rr_ptr + 1'b1;
            2'd2:    start = lfsr[ID_WIDTH-1:0];
            default: start = '0;
        endcase
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = start + ID_WIDTH'(k);
            if (!found && cand[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    assign issue    = found & (gap_cnt == '0) & (~m_valid | m_ready);
    assign gap_sum  = {1'b0, gap_min} + {1'b0, GAP_WIDTH'(lfsr) & gap_mask};
    assign gap_load = gap_sum[GAP_WIDTH] ? '1 : gap_sum[GAP_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_valid  <= 1'b0;
            m_id     <= '0;
            m_data   <= '0;
            m_last   <= 1'b0;
            rr_ptr   <= '1;
            lock_vld <= 1'b0;
            lock_id  <= '0;
            gap_cnt  <= '0;
            lfsr     <= seed_eff;
        end else begin
            if (issue) begin
                m_valid <= 1'b1;
                m_id    <= grant;
                {m_last, m_data} <= pop_ent;
                rr_ptr  <= grant;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (!burst_lock) begin
                lock_vld <= 1'b0;
            end else if (issue) begin
                lock_vld <= ~pop_ent[EW-1];
                lock_id  <= grant;
            end
            if (issue)                gap_cnt <= gap_load;
            else if (gap_cnt != '0)   gap_cnt <= gap_cnt - 1'b1;
            if (seed_rst) lfsr <= seed_eff;
            else          lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

`ifdef ALG_AMBA_VIP_INTERLEAVER_STATS_EN
    logic [ID_WIDTH-1:0] prev_id;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_beats    <= '0;
            stat_switches <= '0;
            prev_id       <= '0;
        end else begin
            if (issue) prev_id <= grant;
            if (stats_clr) begin
                stat_beats    <= '0;
                stat_switches <= '0;
            end else begin
                if (m_valid && m_ready)      stat_beats    <= stat_beats + 32'd1;
                if (issue && grant != prev_id) stat_switches <= stat_switches + 32'd1;
            end
        end
    end
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign stat_beats       = '0;
    assign stat_switches    = '0;
`endif

endmodule

// File: tb/tb_alg_amba_vip_interleaver.sv
// Directed bench for alg_amba_vip_interleaver: ordering, lock, full boundary, gaps, enables, reset.
module tb_alg_amba_vip_interleaver;
    localparam int DW = 128;
    localparam int IW = 4;
    localparam int N  = 16;
`ifdef ALG_AMBA_VIP_INTERLEAVER_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [1:0]    arb_mode = 2'd0;
    logic          burst_lock = 1'b0;
    logic [N-1:0]  id_enable = '1;
    logic [15:0]   gap_min = '0;
    logic [15:0]   gap_mask = '0;
    logic [15:0]   seed = 16'h1234;
    logic          seed_rst = 1'b0;
    logic          stats_clr = 1'b0;
    logic [31:0]   stat_beats;
    logic [31:0]   stat_switches;
    logic          s_valid = 1'b0;
    logic [IW-1:0] s_id = '0;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          m_valid;
    logic [IW-1:0] m_id;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [IW-1:0] q_id[$];
    logic [DW-1:0] q_dat[$];
    logic          q_last[$];
    int            q_cyc[$];

    alg_amba_vip_interleaver dut (
        .clk(clk), .resetn(resetn), .arb_mode(arb_mode), .burst_lock(burst_lock),
        .id_enable(id_enable), .gap_min(gap_min), .gap_mask(gap_mask), .seed(seed),
        .seed_rst(seed_rst), .stats_clr(stats_clr), .stat_beats(stat_beats),
        .stat_switches(stat_switches), .s_valid(s_valid), .s_id(s_id), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready), .m_valid(m_valid), .m_id(m_id),
        .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            q_id.push_back(m_id);
            q_dat.push_back(m_data);
            q_last.push_back(m_last);
            q_cyc.push_back(cyc);
        end
    end

    function automatic logic [DW-1:0] dat(input int id, input int k);
        return {32'(id), 32'(k), 32'hA5A5_0000 | 32'(k), 32'hC0DE_0000 | 32'(id)};
    endfunction

    task automatic clear_q();
        q_id.delete(); q_dat.delete(); q_last.delete(); q_cyc.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        resetn = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        clear_q();
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int id, input int k, input bit last);
        int t;
        t = 0;
        s_valid = 1'b1; s_id = IW'(id); s_data = dat(id, k); s_last = last;
        #1;
        while (!s_ready && t < 200) begin
            @(posedge clk); #2;
            t++;
        end
        if (!s_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: id %0d beat %0d never accepted", id, k);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t;
        t = 0;
        while (q_id.size() < n && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        resetn = 1'b0; s_id = '0;
        @(posedge clk); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %0b want 0", m_valid); end
        checks++; if ({m_id, m_data, m_last} !== '0) begin errors++; $display("FAIL rst_m_bus: got %0h want 0", {m_id, m_data, m_last}); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %0b want 1", s_ready); end
        checks++; if (stat_beats !== 32'd0 || stat_switches !== 32'd0) begin
            errors++; $display("FAIL rst_stats: got %0d/%0d want 0/0", stat_beats, stat_switches); end
        resetn = 1'b1;
    endtask

    task automatic test_fixed_prio();
        int t0;
        int exp_id[4];
        do_reset();
        arb_mode = 2'd0; m_ready = 1'b1;
        t0 = cyc;
        send(3, 0, 1); send(1, 0, 1); send(2, 0, 1);
        wait_out(3);
        checks++; if (q_id.size() != 3) begin errors++; $display("FAIL fp_count: got %0d want 3", q_id.size()); end
        checks++; if (q_cyc[0] != t0 + 2) begin errors++; $display("FAIL fp_latency: got cycle %0d want %0d", q_cyc[0], t0 + 2); end
        checks++; if ({q_id[0], q_id[1], q_id[2]} !== {4'd3, 4'd1, 4'd2}) begin
            errors++; $display("FAIL fp_order: got %0h want 312", {q_id[0], q_id[1], q_id[2]}); end
        checks++; if (q_dat[0] !== dat(3, 0)) begin errors++; $display("FAIL fp_data: got %0h want %0h", q_dat[0], dat(3, 0)); end
        checks++; if (stat_beats !== 32'(3 * STATS)) begin errors++; $display("FAIL fp_stat_beats: got %0d want %0d", stat_beats, 3 * STATS); end
        checks++; if (stat_switches !== 32'(3 * STATS)) begin errors++; $display("FAIL fp_stat_switches: got %0d want %0d", stat_switches, 3 * STATS); end
        // ID 5 occupies the output register; the remaining three are ranked by index.
        clear_q(); m_ready = 1'b0;
        send(5, 1, 1); send(2, 1, 1); send(7, 1, 1); send(1, 1, 1);
        repeat (2) @(posedge clk);
        #1 m_ready = 1'b1;
        wait_out(4);
        exp_id = '{5, 1, 2, 7};
        for (int i = 0; i < 4; i++) begin
            checks++; if (q_id[i] !== IW'(exp_id[i])) begin errors++; $display("FAIL fp_prio[%0d]: got %0d want %0d", i, q_id[i], exp_id[i]); end
        end
    endtask

    task automatic test_round_robin();
        int exp_id[6];
        do_reset();
        arb_mode = 2'd1; m_ready = 1'b1;
        send(9, 0, 1);
        wait_out(1);
        stats_clr = 1'b1; @(posedge clk); #1 stats_clr = 1'b0;
        clear_q(); m_ready = 1'b0;
        send(0, 0, 1); send(0, 1, 1); send(1, 0, 1); send(1, 1, 1); send(2, 0, 1); send(2, 1, 1);
        repeat (2) @(posedge clk);
        #1 m_ready = 1'b1;
        wait_out(6);
        exp_id = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < 6; i++) begin
            checks++; if (q_id[i] !== IW'(exp_id[i])) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, q_id[i], exp_id[i]); end
        end
        checks++; if (q_dat[3] !== dat(0, 1)) begin errors++; $display("FAIL rr_data: got %0h want %0h", q_dat[3], dat(0, 1)); end
        checks++; if (stat_switches !== 32'(6 * STATS)) begin errors++; $display("FAIL rr_stat_switches: got %0d want %0d", stat_switches, 6 * STATS); end
        checks++; if (stat_beats !== 32'(6 * STATS)) begin errors++; $display("FAIL rr_stat_beats: got %0d want %0d", stat_beats, 6 * STATS); end
    endtask

    task automatic test_burst_lock();
        int  exp_id[5];
        bit  exp_last[5];
        do_reset();
        arb_mode = 2'd1; burst_lock = 1'b1; m_ready = 1'b0;
        send(0, 0, 0); send(0, 1, 0); send(0, 2, 1); send(1, 0, 0); send(1, 1, 1);
        repeat (2) @(posedge clk);
        #1 m_ready = 1'b1;
        wait_out(5);
        exp_id   = '{0, 0, 0, 1, 1};
        exp_last = '{0, 0, 1, 0, 1};
        for (int i = 0; i < 5; i++) begin
            checks++; if (q_id[i] !== IW'(exp_id[i]) || q_last[i] !== exp_last[i]) begin
                errors++; $display("FAIL lock[%0d]: got id %0d last %0b want id %0d last %0b", i, q_id[i], q_last[i], exp_id[i], exp_last[i]); end
        end
        burst_lock = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        arb_mode = 2'd0; m_ready = 1'b0;
        send(9, 0, 1);
        for (int k = 0; k < 4; k++) send(5, k, 1);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready: got %0b want 0", s_ready); end
        s_id = 4'd6; #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_other_id: got %0b want 1", s_ready); end
        fork
            send(5, 4, 1);
            begin
                repeat (3) @(posedge clk);
                #1;
                checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_hold: got %0b want 0", s_ready); end
                m_ready = 1'b1;
            end
        join
        wait_out(6);
        checks++; if (q_id.size() != 6) begin errors++; $display("FAIL full_count: got %0d want 6", q_id.size()); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (q_id[k+1] !== 4'd5 || q_dat[k+1] !== dat(5, k)) begin
                errors++; $display("FAIL full_order[%0d]: got id %0d data %0h want id 5 data %0h", k, q_id[k+1], q_dat[k+1], dat(5, k)); end
        end
    endtask

    task automatic test_gap();
        int t;
        do_reset();
        gap_min = 16'd3; gap_mask = 16'd0; m_ready = 1'b1;
        for (int k = 0; k < 5; k++) send(4, k, 1);
        wait_out(5);
        for (int k = 0; k < 4; k++) begin
            checks++; if (q_cyc[k+1] - q_cyc[k] != 4) begin errors++; $display("FAIL gap_spacing[%0d]: got %0d want 4", k, q_cyc[k+1] - q_cyc[k]); end
        end
        checks++; if (q_dat[4] !== dat(4, 4)) begin errors++; $display("FAIL gap_data: got %0h want %0h", q_dat[4], dat(4, 4)); end
        clear_q(); m_ready = 1'b0;
        send(6, 0, 1); send(6, 1, 1);
        t = 0;
        while (!m_valid && t < 50) begin @(posedge clk); #1; t++; end
        for (int c = 0; c < 10; c++) begin
            checks++; if (m_valid !== 1'b1 || m_id !== 4'd6 || m_data !== dat(6, 0)) begin
                errors++; $display("FAIL gap_stall[%0d]: got vld %0b data %0h want vld 1 data %0h", c, m_valid, m_data, dat(6, 0)); end
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        wait_out(2);
        checks++; if (q_dat[0] !== dat(6, 0) || q_dat[1] !== dat(6, 1)) begin
            errors++; $display("FAIL gap_stall_out: got %0h %0h want %0h %0h", q_dat[0], q_dat[1], dat(6, 0), dat(6, 1)); end
        gap_min = 16'd0;
    endtask

    task automatic test_enable_and_reset();
        do_reset();
        arb_mode = 2'd0; m_ready = 1'b0;
        send(8, 0, 1); send(2, 0, 1); send(2, 1, 1);
        id_enable[2] = 1'b0; s_id = 4'd2; #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL en_s_ready: got %0b want 0", s_ready); end
        m_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (q_id.size() != 1 || q_id[0] !== 4'd8) begin
            errors++; $display("FAIL en_hold: got %0d beats first id %0d want 1 beat id 8", q_id.size(), q_id[0]); end
        id_enable[2] = 1'b1;
        wait_out(3);
        checks++; if (q_id[1] !== 4'd2 || q_dat[1] !== dat(2, 0) || q_dat[2] !== dat(2, 1)) begin
            errors++; $display("FAIL en_release: got id %0d data %0h %0h want id 2 data %0h %0h", q_id[1], q_dat[1], q_dat[2], dat(2, 0), dat(2, 1)); end
        clear_q(); m_ready = 1'b0;
        send(3, 0, 1); send(4, 0, 1); send(4, 1, 1);
        resetn = 1'b0;
        @(posedge clk); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid: got %0b want 0", m_valid); end
        resetn = 1'b1; m_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (q_id.size() != 0) begin errors++; $display("FAIL midrst_stale: got %0d beats want 0", q_id.size()); end
    endtask

    initial begin
        test_reset();
        test_fixed_prio();
        test_round_robin();
        test_burst_lock();
        test_full();
        test_gap();
        test_enable_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/alg_amba_vip_interleaver.md
Name: alg_amba_vip_interleaver

Overview:
- Parametrised per-ID reordering/interleaving stage for AMBA VIP response channels (R/B).
- Buffers beats per ID in configurable-depth FIFOs and re-emits them in an order chosen by a runtime arbitration mode.
- Arbitration modes: fixed priority, round-robin, LFSR-random; optional burst lock.
- Adds LFSR-driven inter-beat gaps; sits after the blocking-latency stage, directly before the VIP master port.

Parameters:
DATA_WIDTH, 128, payload width
ID_WIDTH, 4, ID width; number of IDs N = 2**ID_WIDTH
FIFO_LOG2_DEPTH, 2, per-ID FIFO depth = 2**FIFO_LOG2_DEPTH entries
GAP_WIDTH, 16, width of gap counter, gap_min and gap_mask

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
arb_mode  in  2  0 fixed-priority, 1 round-robin, 2 random, 3 = same as 0
burst_lock  in  1  1: hold grant on one ID until its last beat is issued
id_enable  in  N  per-ID enable mask
gap_min  in  GAP_WIDTH  minimum idle cycles after each issued beat
gap_mask  in  GAP_WIDTH  mask ANDed with LFSR for random extra gap
seed  in  16  LFSR seed
seed_rst  in  1  load seed into LFSR
stats_clr  in  1  synchronous clear of statistics counters
stat_beats  out  32  count of m handshakes
stat_switches  out  32  count of issued beats whose ID differs from the previous issued beat
s_valid  in  1  input valid
s_id  in  ID_WIDTH  input ID
s_data  in  DATA_WIDTH  input payload
s_last  in  1  input last beat of burst
s_ready  out  1  input ready
m_valid  out  1  output valid
m_id  out  ID_WIDTH  output ID
m_data  out  DATA_WIDTH  output payload
m_last  out  1  output last
m_ready  in  1  output ready

Behaviour:
- Reset (resetn=0 at posedge): all FIFOs empty, m_valid=0, m_id/m_data/m_last=0, lock cleared, gap counter=0, RR pointer=N-1, previous-ID register=0, stats=0, LFSR=seed (0xACE1 if seed==0). Reset mid-operation discards all buffered beats.
- Input:
  - s_ready = id_enable[s_id] & ~full[s_id], where full is registered.
  - A disabled ID stalls upstream; it never drops data.
  - Write occurs on s_valid & s_ready; each entry stores {s_last, s_data}.
- Candidates: cand[i] = ~empty[i] & id_enable[i]. Disabling an ID with buffered data holds that data until the ID is re-enabled.
- Lock: if burst_lock=1 and lock active, cand is restricted to the locked ID.
  - Lock sets when an issued beat has last=0 (to that ID).
  - Lock clears when an issued beat has last=1.
  - burst_lock=0 clears the lock immediately.
- Arbitration (evaluated each cycle):
  - Mode 0: lowest-index candidate.
  - Mode 1: first candidate strictly after RR pointer, wrapping modulo N. The pointer updates to the granted ID on issue.
  - Mode 2: first candidate at or after lfsr[ID_WIDTH-1:0], wrapping.
  - arb_mode changes take effect on the next arbitration.
- Issue: when any candidate exists, gap counter==0, and (~m_valid | m_ready), the granted FIFO is popped into the output register.
  - m_valid stays high and m_* stay stable while m_valid & ~m_ready.
- Gap: on each issue, the gap counter loads gap_min + (lfsr & gap_mask), saturating at 2**GAP_WIDTH-1. It decrements by 1 per cycle while nonzero. gap_min=gap_mask=0 gives back-to-back issue.
- Latency: a beat accepted in cycle T (uncontended, gap 0) is presented with m_valid=1 in cycle T+2. Sustained throughput is 1 beat/cycle.
- Full boundary: write to a full FIFO is impossible (s_ready=0). A pop and a write to the same ID in one cycle are both honoured. The full flag deasserts the cycle after a pop.
- LFSR: 16-bit Galois, taps 0xB400, advances every cycle. seed_rst has priority over advance.
- Stats:
  - Counters wrap at 2**32.
  - stats_clr takes priority over increment in the same cycle.
  - stat_switches compares against the last issued ID; the first issue after reset counts as a switch iff its ID != 0.

Optional Feature:
ALG_AMBA_VIP_INTERLEAVER_STATS_EN:
- Defined: stat_beats/stat_switches counters and the previous-ID register are implemented as above.
- Undefined: no counter logic; both outputs are tied to 0; stats_clr is ignored.
- Data path behaviour is identical in both cases.

Test Plan:
- Mode 0, gap 0, m_ready=1: send beats IDs 3,1,2 in consecutive cycles T..T+2 -> first output at T+2 is ID 3; final order with all buffered is 1,2 after 3; stat_beats=3.
- Mode 1, burst_lock=0: preload 2 beats each for IDs 0,1,2, then m_ready=1 -> output ID order 0,1,2,0,1,2; stat_switches=6.
- Mode 1, burst_lock=1: ID 0 burst of 3 (last on beat 3), ID 1 burst of 2 both buffered -> 0,0,0,1,1 with no interleave.
- FIFO_LOG2_DEPTH=2, m_ready=0: push 5 beats on ID 5 -> s_ready low after 4th accept; raise m_ready -> 5th accepted, all 5 emerge in order.
- gap_min=3, gap_mask=0, continuous input -> m handshakes exactly every 4 cycles; m_data stable during 10-cycle m_ready=0 stall.
- id_enable[2]=0 with 2 beats buffered on ID 2 -> no ID 2 output and s_ready=0 for s_id=2; re-enable -> both beats issue. Assert resetn=0 mid-stream -> m_valid=0 next cycle and no stale beat after release.
